// File: rtl/ahb_sram_banked.sv
// AHB-lite slave in front of NBANKS single-port 32-bit SRAM macros.
// Posted one-entry write buffer with read merge, read wait states and a two-cycle ERROR response.
module ahb_sram_banked #(
  parameter int unsigned AW          = 9,
  parameter int unsigned NBANKS      = 4,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic                   HCLK,
  input  logic                   HRESETn,
  input  logic                   HSEL,
  input  logic                   HREADY,
  input  logic [1:0]             HTRANS,
  input  logic [2:0]             HSIZE,
  input  logic                   HWRITE,
  input  logic [31:0]            HADDR,
  input  logic [31:0]            HWDATA,
  output logic                   HREADYOUT,
  output logic [1:0]             HRESP,
  output logic [31:0]            HRDATA,
  input  logic [32*NBANKS-1:0]   SRAMRDATA,
  output logic [3:0]             SRAMWEN,
  output logic [31:0]            SRAMWDATA,
  output logic [NBANKS-1:0]      SRAMCS,
  output logic [AW-1:0]          SRAMADDR
);

  localparam int unsigned BB = (NBANKS > 1) ? $clog2(NBANKS) : 0;
  localparam int unsigned BW = (BB > 0) ? BB : 1;
  localparam int unsigned CW = 2;

  typedef enum logic [1:0] {IDLE, RD_WAIT, ERR1, ERR2} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   wait_cnt_q, wait_cnt_d;
  logic [BW-1:0]   buf_bank_q, buf_bank_d;
  logic [AW-1:0]   buf_word_q, buf_word_d;
  logic [3:0]      buf_we_q, buf_we_d;
  logic [31:0]     buf_data_q, buf_data_d;
  logic            buf_pend_q, buf_pend_d;
  logic            buf_data_en_q, buf_data_en_d;
  logic [BW-1:0]   rd_bank_q, rd_bank_d;
  logic [AW-1:0]   rd_word_q, rd_word_d;
  logic [3:0]      rd_mask_q, rd_mask_d;

  logic [BW-1:0]   addr_bank;
  logic [AW-1:0]   addr_word;
  logic [3:0]      addr_lanes;
  logic            illegal;
  logic            bus_ready;
  logic            access;
  logic            legal_read;
  logic            legal_write;
  logic            ram_write;
  logic            buf_hit;
  logic            cs_en;
  logic [BW-1:0]   cs_bank;
  logic [31:0]     ram_word;
  logic            unused_bits;

  assign unused_bits = ^{HTRANS[0], HADDR[31:AW+2+BB]};

  // Address decode and transfer legality
  always_comb begin
    addr_word  = HADDR[AW+1:2];
    addr_bank  = (BB == 0) ? '0 : BW'(HADDR >> (AW + 2));
    illegal    = (HSIZE > 3'b010)
               | ((HSIZE == 3'b001) & HADDR[0])
               | ((HSIZE == 3'b010) & (HADDR[1:0] != 2'b00));
    case (HSIZE[1:0])
      2'b00:   addr_lanes = 4'b0001 << HADDR[1:0];
      2'b01:   addr_lanes = HADDR[1] ? 4'b1100 : 4'b0011;
      default: addr_lanes = 4'b1111;
    endcase
  end

  // New address phases are only taken while the previous data phase completes
  assign bus_ready   = (state_q == IDLE) | (state_q == ERR2);
  assign access      = HSEL & HREADY & HTRANS[1] & bus_ready;
  assign legal_read  = access & ~illegal & ~HWRITE;
  assign legal_write = access & ~illegal & HWRITE;
  assign ram_write   = (buf_pend_q | buf_data_en_q) & ~legal_read & (state_q != RD_WAIT);
  assign buf_hit     = (buf_pend_q | buf_data_en_q) & (buf_we_q != 4'b0000)
                     & (buf_bank_q == addr_bank) & (buf_word_q == addr_word);

  // Next-state logic for FSM, write buffer and read context
  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    buf_bank_d    = buf_bank_q;
    buf_word_d    = buf_word_q;
    buf_we_d      = buf_we_q;
    buf_data_d    = buf_data_q;
    buf_data_en_d = legal_write;
    buf_pend_d    = (buf_pend_q | buf_data_en_q) & ~ram_write;
    rd_bank_d     = rd_bank_q;
    rd_word_d     = rd_word_q;
    rd_mask_d     = rd_mask_q;

    case (state_q)
      IDLE, ERR2: begin
        state_d = IDLE;
        if (access & illegal) begin
          state_d = ERR1;
        end else if (legal_read && (WAIT_STATES > 0)) begin
          state_d    = RD_WAIT;
          wait_cnt_d = CW'(WAIT_STATES - 1);
        end
      end
      RD_WAIT: begin
        if (wait_cnt_q == '0) state_d = IDLE;
        else                  wait_cnt_d = wait_cnt_q - CW'(1);
      end
      ERR1:    state_d = ERR2;
      default: state_d = IDLE;
    endcase

    if (legal_write) begin
      buf_bank_d = addr_bank;
      buf_word_d = addr_word;
      buf_we_d   = addr_lanes;
    end
    if (buf_data_en_q) buf_data_d = HWDATA;

    if (legal_read) begin
      rd_bank_d = addr_bank;
      rd_word_d = addr_word;
      rd_mask_d = buf_hit ? buf_we_q : 4'b0000;
    end
  end

  // SRAM port arbitration: new read, then read re-issue, then buffered write
  always_comb begin
    cs_en     = 1'b0;
    cs_bank   = addr_bank;
    SRAMADDR  = addr_word;
    SRAMWEN   = 4'b0000;
    SRAMWDATA = buf_pend_q ? buf_data_q : HWDATA;
    if (legal_read) begin
      cs_en = 1'b1;
    end else if (state_q == RD_WAIT) begin
      cs_en    = 1'b1;
      cs_bank  = rd_bank_q;
      SRAMADDR = rd_word_q;
    end else if (ram_write) begin
      cs_en    = 1'b1;
      cs_bank  = buf_bank_q;
      SRAMADDR = buf_word_q;
      SRAMWEN  = buf_we_q;
    end
    SRAMCS = '0;
    if (cs_en) SRAMCS[cs_bank] = 1'b1;
  end

  // Read data: selected bank with buffered bytes merged over it
  always_comb begin
    ram_word = '0;
    for (int b = 0; b < NBANKS; b++) begin
      if (BW'(b) == rd_bank_q) ram_word = SRAMRDATA[32*b +: 32];
    end
    for (int i = 0; i < 4; i++) begin
      HRDATA[8*i +: 8] = rd_mask_q[i] ? buf_data_q[8*i +: 8] : ram_word[8*i +: 8];
    end
  end

  assign HREADYOUT = ~((state_q == RD_WAIT) | (state_q == ERR1));
  assign HRESP     = {1'b0, (state_q == ERR1) | (state_q == ERR2)};

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q       <= IDLE;
      wait_cnt_q    <= '0;
      buf_bank_q    <= '0;
      buf_word_q    <= '0;
      buf_we_q      <= '0;
      buf_data_q    <= '0;
      buf_pend_q    <= 1'b0;
      buf_data_en_q <= 1'b0;
      rd_bank_q     <= '0;
      rd_word_q     <= '0;
      rd_mask_q     <= '0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      buf_bank_q    <= buf_bank_d;
      buf_word_q    <= buf_word_d;
      buf_we_q      <= buf_we_d;
      buf_data_q    <= buf_data_d;
      buf_pend_q    <= buf_pend_d;
      buf_data_en_q <= buf_data_en_d;
      rd_bank_q     <= rd_bank_d;
      rd_word_q     <= rd_word_d;
      rd_mask_q     <= rd_mask_d;
    end
  end

endmodule

// File: tb/tb_ahb_sram_banked.sv
// Directed bench for ahb_sram_banked: a zero-wait and a two-wait-state instance sharing one bus,
// each backed by a behavioural SRAM; read data checked through per-instance scoreboards.
module tb_ahb_sram_banked;

  localparam int unsigned AW = 9;
  localparam int unsigned NB = 4;

  logic        HCLK = 1'b0;
  logic        HRESETn = 1'b0;
  logic        hsel0, hsel2, hwrite;
  logic [1:0]  htrans;
  logic [2:0]  hsize;
  logic [31:0] haddr, hwdata;

  logic        hreadyout0, hreadyout2;
  logic [1:0]  hresp0, hresp2;
  logic [31:0] hrdata0, hrdata2;
  logic [32*NB-1:0] srd0, srd2;
  logic [3:0]  swen0, swen2;
  logic [31:0] swd0, swd2;
  logic [NB-1:0] scs0, scs2;
  logic [AW-1:0] saddr0, saddr2;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] sb0[$];
  logic [31:0] sb2[$];

  always #5 HCLK = ~HCLK;

  ahb_sram_banked #(.AW(AW), .NBANKS(NB), .WAIT_STATES(0)) u_dut0 (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(hsel0), .HREADY(hreadyout0), .HTRANS(htrans),
    .HSIZE(hsize), .HWRITE(hwrite), .HADDR(haddr), .HWDATA(hwdata),
    .HREADYOUT(hreadyout0), .HRESP(hresp0), .HRDATA(hrdata0), .SRAMRDATA(srd0),
    .SRAMWEN(swen0), .SRAMWDATA(swd0), .SRAMCS(scs0), .SRAMADDR(saddr0));

  ahb_sram_banked #(.AW(AW), .NBANKS(NB), .WAIT_STATES(2)) u_dut2 (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(hsel2), .HREADY(hreadyout2), .HTRANS(htrans),
    .HSIZE(hsize), .HWRITE(hwrite), .HADDR(haddr), .HWDATA(hwdata),
    .HREADYOUT(hreadyout2), .HRESP(hresp2), .HRDATA(hrdata2), .SRAMRDATA(srd2),
    .SRAMWEN(swen2), .SRAMWDATA(swd2), .SRAMCS(scs2), .SRAMADDR(saddr2));

  // Behavioural synchronous SRAM banks (read data one cycle after CS)
  logic [31:0] mem0 [NB][2**AW];
  logic [31:0] mem2 [NB][2**AW];
  logic [31:0] rq0 [NB] = '{default: 32'h0};
  logic [31:0] rq2 [NB] = '{default: 32'h0};
  logic loaded = 1'b0;

  assign srd0 = {rq0[3], rq0[2], rq0[1], rq0[0]};
  assign srd2 = {rq2[3], rq2[2], rq2[1], rq2[0]};

  always @(posedge HCLK) begin
    if (!loaded) begin
      mem0[0][0] <= 32'h11223344;
      mem0[1][1] <= 32'h01010101;
      mem2[2][2] <= 32'hCAFEF00D;
      mem2[1][3] <= 32'h0BADC0DE;
      loaded     <= 1'b1;
    end
    for (int b = 0; b < NB; b++) begin
      if (scs0[b]) begin
        if (swen0 != 4'b0000) begin
          for (int i = 0; i < 4; i++) if (swen0[i]) mem0[b][saddr0][8*i +: 8] <= swd0[8*i +: 8];
        end else begin
          rq0[b] <= mem0[b][saddr0];
        end
      end
      if (scs2[b]) begin
        if (swen2 != 4'b0000) begin
          for (int i = 0; i < 4; i++) if (swen2[i]) mem2[b][saddr2][8*i +: 8] <= swd2[8*i +: 8];
        end else begin
          rq2[b] <= mem2[b][saddr2];
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic pop0(input string tag);
    if (sb0.size() == 0) begin
      n_checks++; n_errors++;
      $error("FAIL %s observed=0x%08h expected=<empty scoreboard>", tag, hrdata0);
    end else check(tag, hrdata0, sb0.pop_front());
  endtask

  task automatic pop2(input string tag);
    if (sb2.size() == 0) begin
      n_checks++; n_errors++;
      $error("FAIL %s observed=0x%08h expected=<empty scoreboard>", tag, hrdata2);
    end else check(tag, hrdata2, sb2.pop_front());
  endtask

  task automatic tick();
    @(posedge HCLK); #1;
  endtask

  task automatic drive(input logic s0, input logic s2, input logic w, input logic [2:0] sz,
                       input logic [31:0] a);
    hsel0 = s0; hsel2 = s2; htrans = (s0 | s2) ? 2'b10 : 2'b00;
    hwrite = w; hsize = sz; haddr = a;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 3'b010, 32'h0);
  endtask

  // Waits out dut2 read wait states; counts low-ready cycles and chip-select cycles seen
  task automatic wait_rdy2(input logic [3:0] cs_exp, output int lows, output int css);
    lows = 0; css = 0;
    for (int i = 0; i < 8 && hreadyout2 == 1'b0; i++) begin
      lows++;
      if (scs2 == cs_exp) css++;
      tick(); #2;
    end
    check("rd2_ready_timeout", 32'(hreadyout2), 32'd1);
  endtask

  // At most one chip select per cycle on either instance
  always @(negedge HCLK) begin
    if (HRESETn) begin
      check("cs0_onehot", 32'($countones(scs0) <= 1), 32'd1);
      check("cs2_onehot", 32'($countones(scs2) <= 1), 32'd1);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lows, css;
    idle(); hwdata = 32'h0; HRESETn = 1'b0;
    repeat (2) tick();
    #2;
    check("rst_rdy0", 32'(hreadyout0), 32'd1);
    check("rst_resp0", 32'(hresp0), 32'd0);
    check("rst_cs0", 32'(scs0), 32'd0);
    check("rst_wen0", 32'(swen0), 32'd0);
    check("rst_rdy2", 32'(hreadyout2), 32'd1);
    check("rst_cs2", 32'(scs2), 32'd0);
    tick(); HRESETn = 1'b1;
    tick();

    // Word write then read of same word: merge, then drain on the idle cycle
    drive(1, 0, 1, 3'b010, 32'h804); #2;
    check("A_ap_wen", 32'(swen0), 32'h0);
    check("A_ap_cs", 32'(scs0), 32'h0);
    tick(); hwdata = 32'hDEADBEEF; drive(1, 0, 0, 3'b010, 32'h804); sb0.push_back(32'hDEADBEEF); #2;
    check("A_rd_cs", 32'(scs0), 32'h2);
    check("A_rd_addr", 32'(saddr0), 32'd1);
    check("A_rd_wen", 32'(swen0), 32'h0);
    tick(); idle(); hwdata = 32'h0; #2;
    check("A_rd_rdy", 32'(hreadyout0), 32'd1);
    pop0("A_merge");
    check("A_drain_wen", 32'(swen0), 32'hF);
    check("A_drain_cs", 32'(scs0), 32'h2);
    check("A_drain_addr", 32'(saddr0), 32'd1);
    check("A_drain_wdata", swd0, 32'hDEADBEEF);
    tick(); #2;
    check("A_after_wen", 32'(swen0), 32'h0);
    tick(); drive(1, 0, 0, 3'b010, 32'h804); sb0.push_back(32'hDEADBEEF); #2;
    tick(); idle(); #2;
    pop0("A_readback");

    // Byte write to lane 3 then immediate word read: partial merge
    tick(); drive(1, 0, 1, 3'b000, 32'h3); #2;
    tick(); hwdata = 32'hAA000000; drive(1, 0, 0, 3'b010, 32'h0); sb0.push_back(32'hAA223344); #2;
    check("B_rd_cs", 32'(scs0), 32'h1);
    check("B_rd_wen", 32'(swen0), 32'h0);
    tick(); idle(); hwdata = 32'h0; #2;
    pop0("B_merge");
    check("B_drain_wen", 32'(swen0), 32'h8);
    check("B_drain_cs", 32'(scs0), 32'h1);
    check("B_drain_byte", 32'(swd0[31:24]), 32'hAA);
    tick(); drive(1, 0, 0, 3'b010, 32'h0); sb0.push_back(32'hAA223344); #2;
    tick(); idle(); #2;
    pop0("B_readback");

    // Write bank 3, read bank 0, read the buffered word: drain deferred to idle
    tick(); drive(1, 0, 1, 3'b010, 32'h1814); #2;
    tick(); hwdata = 32'h12345678; drive(1, 0, 0, 3'b010, 32'h0); sb0.push_back(32'hAA223344); #2;
    check("E_rd1_wen", 32'(swen0), 32'h0);
    check("E_rd1_cs", 32'(scs0), 32'h1);
    tick(); hwdata = 32'h0; drive(1, 0, 0, 3'b010, 32'h1814); sb0.push_back(32'h12345678); #2;
    pop0("E_rd1");
    check("E_rd2_wen", 32'(swen0), 32'h0);
    check("E_rd2_cs", 32'(scs0), 32'h8);
    check("E_rd2_addr", 32'(saddr0), 32'd5);
    tick(); idle(); #2;
    pop0("E_rd2_merge");
    check("E_drain_wen", 32'(swen0), 32'hF);
    check("E_drain_cs", 32'(scs0), 32'h8);
    check("E_drain_addr", 32'(saddr0), 32'd5);
    check("E_drain_wdata", swd0, 32'h12345678);
    tick(); #2;
    check("E_after_wen", 32'(swen0), 32'h0);

    // Back-to-back writes: each drains in the following cycle
    tick(); drive(1, 0, 1, 3'b010, 32'h10); #2;
    tick(); hwdata = 32'hA1A1A1A1; drive(1, 0, 1, 3'b010, 32'h14); #2;
    check("W2_drain1_wen", 32'(swen0), 32'hF);
    check("W2_drain1_addr", 32'(saddr0), 32'd4);
    check("W2_drain1_wdata", swd0, 32'hA1A1A1A1);
    tick(); hwdata = 32'hB2B2B2B2; idle(); #2;
    check("W2_drain2_wen", 32'(swen0), 32'hF);
    check("W2_drain2_addr", 32'(saddr0), 32'd5);
    check("W2_drain2_wdata", swd0, 32'hB2B2B2B2);
    tick(); hwdata = 32'h0; drive(1, 0, 0, 3'b010, 32'h10); sb0.push_back(32'hA1A1A1A1); #2;
    check("W2_rd_wen", 32'(swen0), 32'h0);
    tick(); drive(1, 0, 0, 3'b010, 32'h14); sb0.push_back(32'hB2B2B2B2); #2;
    pop0("W2_rd1");
    tick(); idle(); #2;
    pop0("W2_rd2");

    // Illegal transfers: misaligned halfword read, then HSIZE=3'b011 write
    tick(); drive(1, 0, 0, 3'b001, 32'h1); #2;
    check("D1_ap_cs", 32'(scs0), 32'h0);
    tick(); idle(); hwdata = 32'hFFFFFFFF; #2;
    check("D1_e1_rdy", 32'(hreadyout0), 32'd0);
    check("D1_e1_resp", 32'(hresp0), 32'd1);
    check("D1_e1_cs", 32'(scs0), 32'h0);
    tick(); #2;
    check("D1_e2_rdy", 32'(hreadyout0), 32'd1);
    check("D1_e2_resp", 32'(hresp0), 32'd1);
    tick(); #2;
    check("D1_done_resp", 32'(hresp0), 32'd0);
    tick(); drive(1, 0, 1, 3'b011, 32'h0); #2;
    check("D2_ap_wen", 32'(swen0), 32'h0);
    check("D2_ap_cs", 32'(scs0), 32'h0);
    tick(); idle(); #2;
    check("D2_e1_rdy", 32'(hreadyout0), 32'd0);
    check("D2_e1_resp", 32'(hresp0), 32'd1);
    check("D2_e1_wen", 32'(swen0), 32'h0);
    tick(); hwdata = 32'h0; #2;
    check("D2_e2_rdy", 32'(hreadyout0), 32'd1);
    check("D2_e2_resp", 32'(hresp0), 32'd1);
    check("D2_e2_wen", 32'(swen0), 32'h0);
    tick(); drive(1, 0, 0, 3'b010, 32'h0); sb0.push_back(32'hAA223344); #2;
    check("D_rd_cs", 32'(scs0), 32'h1);
    tick(); idle(); #2;
    pop0("D_buf_unchanged");

    // Two wait states: read of bank 2 word 2
    tick(); drive(0, 1, 0, 3'b010, 32'h1008); sb2.push_back(32'hCAFEF00D); #2;
    check("C_ap_cs", 32'(scs2), 32'h4);
    check("C_ap_addr", 32'(saddr2), 32'd2);
    tick(); idle(); #2;
    wait_rdy2(4'h4, lows, css);
    check("C_low_cycles", 32'(lows), 32'd2);
    check("C_cs_cycles", 32'(css + 1), 32'd3);
    pop2("C_rdata");
    check("C_final_cs", 32'(scs2), 32'h0);

    // Reset during read wait with a buffered write pending
    tick(); drive(0, 1, 1, 3'b010, 32'h80C); #2;
    tick(); hwdata = 32'h55AA55AA; drive(0, 1, 0, 3'b010, 32'h1008); #2;
    check("F_rd_wen", 32'(swen2), 32'h0);
    check("F_rd_cs", 32'(scs2), 32'h4);
    tick(); idle(); hwdata = 32'h0; #2;
    check("F_wait_rdy", 32'(hreadyout2), 32'd0);
    HRESETn = 1'b0; #1;
    check("F_rst_rdy", 32'(hreadyout2), 32'd1);
    check("F_rst_resp", 32'(hresp2), 32'd0);
    check("F_rst_cs", 32'(scs2), 32'h0);
    check("F_rst_wen", 32'(swen2), 32'h0);
    tick(); HRESETn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick(); #2;
      check("F_no_stale_wen", 32'(swen2), 32'h0);
      check("F_no_stale_cs", 32'(scs2), 32'h0);
    end
    tick(); drive(0, 1, 0, 3'b010, 32'h80C); sb2.push_back(32'h0BADC0DE); #2;
    check("F_rd_cs_after", 32'(scs2), 32'h2);
    tick(); idle(); #2;
    wait_rdy2(4'h2, lows, css);
    pop2("F_no_stale_data");

    tick(); tick();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
